// File: rtl/mips_run_ctrl.sv
`timescale 1ns/1ps
// mips_run_ctrl
// Run controller for the pipelined MIPS core. Holds the core in reset for a
// programmable number of cycles after start, then counts RUN cycles and
// retired GRF writes, ends the run on a PC stall (halt) or a cycle budget
// (timeout), and keeps a circular trace of the most recent GRF writes.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   start               one-cycle run request (honoured in IDLE and DONE)
//   pc                  core fetch PC
//   wb_valid/addr/data  core GRF write port
//   cpu_reset           reset to the core (low only while running)
//   running             high in RUN
//   done, timeout       sticky end-of-run flags; timeout = ended by budget
//   cycle_cnt, wb_cnt   RUN cycles and counted GRF writes (saturating)
//   trd_en              pop the trace head
//   trd_data            show-ahead head entry {wb_addr, wb_data}, 0 when empty
//   trace_empty, trace_count, trace_overflow  trace buffer status
module mips_run_ctrl #(
  parameter int PC_W         = 32,
  parameter int CNT_W        = 32,
  parameter int RESET_CYCLES = 2,
  parameter int MAX_CYCLES   = 1000,
  parameter int HALT_REPEAT  = 4,
  parameter int TRACE_DEPTH  = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [PC_W-1:0]                pc,
  input  logic                           wb_valid,
  input  logic [4:0]                     wb_addr,
  input  logic [31:0]                    wb_data,
  output logic                           cpu_reset,
  output logic                           running,
  output logic                           done,
  output logic                           timeout,
  output logic [CNT_W-1:0]               cycle_cnt,
  output logic [CNT_W-1:0]               wb_cnt,
  input  logic                           trd_en,
  output logic [36:0]                    trd_data,
  output logic                           trace_empty,
  output logic [$clog2(TRACE_DEPTH):0]   trace_count,
  output logic                           trace_overflow
);

  localparam int PTR_W  = $clog2(TRACE_DEPTH);
  localparam int TC_W   = PTR_W + 1;
  localparam int RST_W  = $clog2(RESET_CYCLES + 1);
  localparam int SAME_W = $clog2(HALT_REPEAT + 1);

  typedef enum logic [1:0] {IDLE, RST, RUN, DONE} state_t;

  state_t              state, state_nxt;
  logic [RST_W-1:0]    rst_cnt;
  logic [SAME_W-1:0]   same_cnt;
  logic [PC_W-1:0]     pc_q;
  logic                pc_q_vld;
  logic                start_rst;
  logic                halt_hit;
  logic                tmo_hit;
  logic [CNT_W-1:0]    cycle_inc;
  logic                push;
  logic                pop;
  logic                full;
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [36:0]         trace_mem [TRACE_DEPTH];

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Equal-PC run length never needs to exceed the halt threshold.
  function automatic logic [SAME_W-1:0] same_inc(input logic [SAME_W-1:0] v);
    return (v == SAME_W'(HALT_REPEAT)) ? v : v + SAME_W'(1);
  endfunction

  assign cycle_inc = sat_inc(cycle_cnt);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cpu_reset = 1'b1;
    running   = 1'b0;
    start_rst = 1'b0;
    halt_hit  = 1'b0;
    tmo_hit   = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt = RST;
          start_rst = 1'b1;
        end
      end
      RST: begin
        if (rst_cnt == RST_W'(RESET_CYCLES - 1)) state_nxt = RUN;
      end
      RUN: begin
        cpu_reset = 1'b0;
        running   = 1'b1;
        // Halt is judged on the registered run length; timeout on the count
        // this edge produces, so the core runs exactly MAX_CYCLES cycles.
        halt_hit  = (same_cnt == SAME_W'(HALT_REPEAT));
        tmo_hit   = (cycle_inc == CNT_W'(MAX_CYCLES));
        if (halt_hit || tmo_hit) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---- run counters, halt detection, end-of-run flags ----
  always_ff @(posedge clk) begin
    if (reset || start_rst) begin
      rst_cnt   <= '0;
      same_cnt  <= '0;
      pc_q_vld  <= 1'b0;
      cycle_cnt <= '0;
      wb_cnt    <= '0;
      done      <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      case (state)
        RST: begin
          rst_cnt  <= rst_cnt + RST_W'(1);
          pc_q_vld <= 1'b0;
        end
        RUN: begin
          cycle_cnt <= cycle_inc;
          if (push) wb_cnt <= sat_inc(wb_cnt);
          pc_q_vld  <= 1'b1;
          same_cnt  <= (pc_q_vld && pc == pc_q) ? same_inc(same_cnt) : '0;
          if (halt_hit) begin
            done    <= 1'b1;
            timeout <= 1'b0;
          end else if (tmo_hit) begin
            done    <= 1'b1;
            timeout <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == RUN) pc_q <= pc;
  end

  // ---- trace buffer ----
  assign push        = running && wb_valid && (wb_addr != 5'd0);
  assign pop         = trd_en && !trace_empty;
  assign full        = (trace_count == TC_W'(TRACE_DEPTH));
  assign trace_empty = (trace_count == '0);
  assign trd_data    = trace_empty ? '0 : trace_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) trace_mem[wr_ptr] <= {wb_addr, wb_data};
  end

  always_ff @(posedge clk) begin
    if (reset || start_rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      trace_count    <= '0;
      trace_overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      // A push into a full buffer drops the oldest entry, so the read
      // pointer moves with it even without a pop.
      if (pop || (push && full)) rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop && !full)  trace_count <= trace_count + TC_W'(1);
      else if (pop && !push)      trace_count <= trace_count - TC_W'(1);
      if (push && full && !pop)   trace_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mips_run_ctrl.sv
`timescale 1ns/1ps
module tb_mips_run_ctrl;
  localparam int RC = 2;
  localparam int MC = 20;
  localparam int HR = 4;
  localparam int TD = 8;

  logic        clk = 1'b0;
  logic        reset, start, wb_valid, trd_en;
  logic [31:0] pc, wb_data;
  logic [4:0]  wb_addr;
  logic        cpu_reset, running, done, timeout;
  logic [31:0] cycle_cnt, wb_cnt;
  logic [36:0] trd_data;
  logic        trace_empty, trace_overflow;
  logic [3:0]  trace_count;

  always #5 clk = ~clk;

  mips_run_ctrl #(
    .PC_W(32), .CNT_W(32), .RESET_CYCLES(RC), .MAX_CYCLES(MC),
    .HALT_REPEAT(HR), .TRACE_DEPTH(TD)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .pc(pc),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .cpu_reset(cpu_reset), .running(running), .done(done), .timeout(timeout),
    .cycle_cnt(cycle_cnt), .wb_cnt(wb_cnt), .trd_en(trd_en), .trd_data(trd_data),
    .trace_empty(trace_empty), .trace_count(trace_count),
    .trace_overflow(trace_overflow)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Per-RUN-cycle stimulus (index 1 = first RUN cycle) and observations.
  logic [31:0] pc_seq [64];
  bit          wv_seq [64];
  logic [4:0]  wa_seq [64];
  logic [31:0] wd_seq [64];
  bit          rd_seq [64];
  bit          obs_cr [64];
  logic [3:0]  obs_tc [64];
  bit          obs_ovf[64];
  int          run_edges;

  // Reference model state.
  logic [36:0] mq[$];
  bit          m_ovf;
  int          m_wb;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_seq();
    for (int i = 0; i < 64; i++) begin
      pc_seq[i] = 32'h1000 + 32'(4 * i);
      wv_seq[i] = 1'b0;
      wa_seq[i] = 5'd0;
      wd_seq[i] = 32'd0;
      rd_seq[i] = 1'b0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; wb_valid = 1'b0; trd_en = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Pulse start, sit out the core reset, then play the stimulus until done.
  task automatic play_run(input int budget);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < RC; k++) tick();
    run_edges = budget + 1;
    for (int i = 1; i <= budget; i++) begin
      pc = pc_seq[i]; wb_valid = wv_seq[i]; wb_addr = wa_seq[i];
      wb_data = wd_seq[i]; trd_en = rd_seq[i];
      tick();
      obs_cr[i] = cpu_reset; obs_tc[i] = trace_count; obs_ovf[i] = trace_overflow;
      if (done) begin
        run_edges = i;
        break;
      end
    end
    wb_valid = 1'b0;
    trd_en   = 1'b0;
  endtask

  // The run ends at the first cycle n preceded by HR+1 cycles with one PC,
  // or at n == MC; a halt on the budget cycle still counts as a halt.
  function automatic int model_end(output bit by_halt);
    bit eq;
    by_halt = 1'b0;
    for (int n = 1; n <= MC; n++) begin
      if (n - 1 - HR >= 1) begin
        eq = 1'b1;
        for (int j = n - 1 - HR; j < n - 1; j++)
          if (pc_seq[j] !== pc_seq[j + 1]) eq = 1'b0;
        if (eq) begin
          by_halt = 1'b1;
          return n;
        end
      end
      if (n == MC) return n;
    end
    return MC;
  endfunction

  task automatic model_trace(input int n_end);
    mq.delete();
    m_ovf = 1'b0;
    m_wb  = 0;
    for (int i = 1; i <= n_end; i++) begin
      if (rd_seq[i] && mq.size() > 0) void'(mq.pop_front());
      if (wv_seq[i] && wa_seq[i] != 5'd0) begin
        m_wb++;
        mq.push_back({wa_seq[i], wd_seq[i]});
        if (mq.size() > TD) begin
          void'(mq.pop_front());
          m_ovf = 1'b1;
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; trd_en = 1'b1;
    pc = $urandom(); wb_valid = 1'b1; wb_addr = 5'd3; wb_data = $urandom();
    tick();
    tick();
    reset = 1'b0; start = 1'b0; trd_en = 1'b0; wb_valid = 1'b0;
    n_checks++;
    if ({cpu_reset, running, done, timeout, trace_empty, trace_overflow} !== 6'b100010)
      $display("FAIL reset_flags: got %b want 100010",
               {cpu_reset, running, done, timeout, trace_empty, trace_overflow});
    else n_pass++;
    n_checks++;
    if ({cycle_cnt, wb_cnt, trace_count} !== 68'd0)
      $display("FAIL reset_counts: got cyc=%0d wb=%0d tc=%0d want 0", cycle_cnt, wb_cnt, trace_count);
    else n_pass++;
    n_checks++;
    if (trd_data !== 37'd0) $display("FAIL reset_trd: got %h want 0", trd_data);
    else n_pass++;
    tick();
    tick();
    n_checks++;
    if ({cpu_reset, running, cycle_cnt} !== {2'b10, 32'd0})
      $display("FAIL idle_hold: got cr=%b run=%b cyc=%0d want 1 0 0", cpu_reset, running, cycle_cnt);
    else n_pass++;
  endtask

  task automatic test_start_timing();
    pc = 32'h400;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++;
    if ({cpu_reset, running} !== 2'b10)
      $display("FAIL start_edge: got cr=%b run=%b want 1 0", cpu_reset, running);
    else n_pass++;
    pc += 4;
    tick();
    n_checks++;
    if (cpu_reset !== 1'b1) $display("FAIL rst_cycle2: got cr=%b want 1", cpu_reset);
    else n_pass++;
    pc += 4;
    tick();
    n_checks++;
    if ({cpu_reset, running, cycle_cnt} !== {2'b01, 32'd0})
      $display("FAIL run_entry: got cr=%b run=%b cyc=%0d want 0 1 0", cpu_reset, running, cycle_cnt);
    else n_pass++;
    pc += 4;
    tick();
    n_checks++;
    if (cycle_cnt !== 32'd1) $display("FAIL first_cycle: got %0d want 1", cycle_cnt);
    else n_pass++;
    start = 1'b1;
    pc += 4;
    tick();
    start = 1'b0;
    n_checks++;
    if ({running, cycle_cnt} !== {1'b1, 32'd2})
      $display("FAIL start_in_run: got run=%b cyc=%0d want 1 2", running, cycle_cnt);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    wb_valid = 1'b1; wb_addr = 5'd7; wb_data = $urandom();
    pc += 4;
    tick();
    wb_valid = 1'b0;
    n_checks++;
    if ({wb_cnt, trace_count} !== {32'd1, 4'd1})
      $display("FAIL pre_reset_wb: got wb=%0d tc=%0d want 1 1", wb_cnt, trace_count);
    else n_pass++;
    n_checks++;
    if (trd_data !== {5'd7, wb_data}) $display("FAIL pre_reset_trd: got %h want %h", trd_data, {5'd7, wb_data});
    else n_pass++;
    reset = 1'b1;
    pc += 4;
    tick();
    reset = 1'b0;
    n_checks++;
    if ({cpu_reset, running, done, timeout, trace_empty, trace_overflow} !== 6'b100010)
      $display("FAIL midreset_flags: got %b want 100010",
               {cpu_reset, running, done, timeout, trace_empty, trace_overflow});
    else n_pass++;
    n_checks++;
    if ({cycle_cnt, wb_cnt, trace_count, trd_data} !== 105'd0)
      $display("FAIL midreset_counts: got cyc=%0d wb=%0d tc=%0d trd=%h want 0", cycle_cnt, wb_cnt, trace_count, trd_data);
    else n_pass++;
  endtask

  task automatic test_halt();
    bit bh;
    int me;
    clear_seq();
    pc_seq[1] = 32'h3000;
    pc_seq[2] = 32'h3004;
    for (int i = 3; i < 64; i++) pc_seq[i] = 32'h3008;
    play_run(30);
    me = model_end(bh);
    n_checks++;
    if (run_edges !== 8) $display("FAIL halt_edge: got %0d want 8", run_edges);
    else n_pass++;
    n_checks++;
    if (me !== run_edges || bh !== 1'b1) $display("FAIL halt_model: got %0d want %0d", run_edges, me);
    else n_pass++;
    n_checks++;
    if ({done, timeout, cpu_reset, running} !== 4'b1010)
      $display("FAIL halt_flags: got %b want 1010", {done, timeout, cpu_reset, running});
    else n_pass++;
    n_checks++;
    if (obs_cr[7] !== 1'b0) $display("FAIL halt_prev_cr: got %b want 0", obs_cr[7]);
    else n_pass++;
    for (int k = 0; k < 3; k++) begin
      pc += 4;
      tick();
    end
    n_checks++;
    if ({cycle_cnt, done, cpu_reset} !== {32'd8, 2'b11})
      $display("FAIL halt_freeze: got cyc=%0d done=%b cr=%b want 8 1 1", cycle_cnt, done, cpu_reset);
    else n_pass++;
  endtask

  task automatic test_timeout();
    clear_seq();
    play_run(30);
    n_checks++;
    if ({run_edges, cycle_cnt} !== {32'd20, 32'd20})
      $display("FAIL tmo_edge: got edge=%0d cyc=%0d want 20 20", run_edges, cycle_cnt);
    else n_pass++;
    n_checks++;
    if ({done, timeout} !== 2'b11) $display("FAIL tmo_flags: got %b want 11", {done, timeout});
    else n_pass++;
    // PC freezes from cycle 15: the halt lands on the budget cycle.
    clear_seq();
    for (int i = 16; i < 64; i++) pc_seq[i] = pc_seq[15];
    play_run(30);
    n_checks++;
    if ({run_edges, cycle_cnt} !== {32'd20, 32'd20})
      $display("FAIL tie_edge: got edge=%0d cyc=%0d want 20 20", run_edges, cycle_cnt);
    else n_pass++;
    n_checks++;
    if ({done, timeout} !== 2'b10) $display("FAIL tie_flags: got %b want 10", {done, timeout});
    else n_pass++;
  endtask

  task automatic test_trace_filter();
    clear_seq();
    wv_seq[2] = 1'b1; wa_seq[2] = 5'd0;  wd_seq[2] = 32'hdead;
    wv_seq[3] = 1'b1; wa_seq[3] = 5'd5;  wd_seq[3] = 32'h12;
    wv_seq[4] = 1'b1; wa_seq[4] = 5'd31; wd_seq[4] = 32'h3010;
    play_run(30);
    n_checks++;
    if (wb_cnt !== 32'd2) $display("FAIL filt_wbcnt: got %0d want 2", wb_cnt);
    else n_pass++;
    n_checks++;
    if ({obs_tc[2], obs_tc[3], obs_tc[4]} !== {4'd0, 4'd1, 4'd2})
      $display("FAIL filt_latency: got %0d %0d %0d want 0 1 2", obs_tc[2], obs_tc[3], obs_tc[4]);
    else n_pass++;
    n_checks++;
    if (trd_data !== {5'd5, 32'h12}) $display("FAIL filt_pop1: got %h want %h", trd_data, {5'd5, 32'h12});
    else n_pass++;
    trd_en = 1'b1;
    tick();
    trd_en = 1'b0;
    n_checks++;
    if (trd_data !== {5'd31, 32'h3010}) $display("FAIL filt_pop2: got %h want %h", trd_data, {5'd31, 32'h3010});
    else n_pass++;
    trd_en = 1'b1;
    tick();
    n_checks++;
    if ({trace_empty, trd_data} !== {1'b1, 37'd0})
      $display("FAIL filt_empty: got empty=%b trd=%h want 1 0", trace_empty, trd_data);
    else n_pass++;
    tick();
    trd_en = 1'b0;
    n_checks++;
    if ({trace_count, trace_empty} !== {4'd0, 1'b1})
      $display("FAIL pop_empty: got tc=%0d empty=%b want 0 1", trace_count, trace_empty);
    else n_pass++;
  endtask

  task automatic test_overflow();
    clear_seq();
    for (int i = 1; i <= 10; i++) begin
      wv_seq[i] = 1'b1; wa_seq[i] = 5'(i); wd_seq[i] = 32'h1000 + 32'(i);
    end
    play_run(30);
    n_checks++;
    if ({trace_count, trace_overflow, wb_cnt} !== {4'd8, 1'b1, 32'd10})
      $display("FAIL ovf_state: got tc=%0d ovf=%b wb=%0d want 8 1 10", trace_count, trace_overflow, wb_cnt);
    else n_pass++;
    for (int i = 3; i <= 10; i++) begin
      n_checks++;
      if (trd_data !== {5'(i), 32'h1000 + 32'(i)})
        $display("FAIL ovf_drain%0d: got %h want %h", i, trd_data, {5'(i), 32'h1000 + 32'(i)});
      else n_pass++;
      trd_en = 1'b1;
      tick();
      trd_en = 1'b0;
    end
    clear_seq();
    for (int i = 1; i <= 9; i++) begin
      wv_seq[i] = 1'b1; wa_seq[i] = 5'(i); wd_seq[i] = 32'h2000 + 32'(i);
    end
    rd_seq[9] = 1'b1;
    play_run(30);
    n_checks++;
    if ({obs_tc[8], obs_ovf[8], obs_tc[9], obs_ovf[9]} !== {4'd8, 1'b0, 4'd8, 1'b0})
      $display("FAIL full_pushpop: got tc8=%0d ovf8=%b tc9=%0d ovf9=%b want 8 0 8 0",
               obs_tc[8], obs_ovf[8], obs_tc[9], obs_ovf[9]);
    else n_pass++;
    n_checks++;
    if ({trd_data, trace_overflow} !== {5'd2, 32'h2002, 1'b0})
      $display("FAIL full_head: got %h ovf=%b want %h 0", trd_data, trace_overflow, {5'd2, 32'h2002});
    else n_pass++;
  endtask

  task automatic test_restart();
    clear_seq();
    for (int i = 1; i <= 12; i++) begin
      wv_seq[i] = 1'b1; wa_seq[i] = 5'(i + 3); wd_seq[i] = $urandom();
    end
    play_run(30);
    n_checks++;
    if ({done, trace_overflow, trace_count} !== {2'b11, 4'd8})
      $display("FAIL restart_pre: got done=%b ovf=%b tc=%0d want 1 1 8", done, trace_overflow, trace_count);
    else n_pass++;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++;
    if ({cpu_reset, running, done, timeout, trace_empty, trace_overflow} !== 6'b100010)
      $display("FAIL restart_flags: got %b want 100010",
               {cpu_reset, running, done, timeout, trace_empty, trace_overflow});
    else n_pass++;
    n_checks++;
    if ({cycle_cnt, wb_cnt, trace_count} !== 68'd0)
      $display("FAIL restart_counts: got cyc=%0d wb=%0d tc=%0d want 0", cycle_cnt, wb_cnt, trace_count);
    else n_pass++;
    do_reset();
  endtask

  task automatic test_random();
    bit bh;
    int me, p, cr_low, lim;
    logic [36:0] exp_e;
    for (int r = 0; r < 12; r++) begin
      clear_seq();
      p = (r % 3 == 0) ? 10 : ((r % 3 == 1) ? 50 : 85);
      pc_seq[1] = {$urandom_range(0, 16'hffff), 16'h0} & 32'hffff_fffc;
      for (int i = 2; i < 64; i++)
        pc_seq[i] = ($urandom_range(0, 99) < p) ? pc_seq[i - 1] : pc_seq[i - 1] + 32'd4;
      for (int i = 1; i < 64; i++) begin
        wv_seq[i] = ($urandom_range(0, 1) == 1);
        wa_seq[i] = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        wd_seq[i] = $urandom();
        rd_seq[i] = ($urandom_range(0, 3) == 0);
      end
      play_run(30);
      me = model_end(bh);
      model_trace(me);
      n_checks++;
      if (run_edges !== me) $display("FAIL rnd%0d_end: got %0d want %0d", r, run_edges, me);
      else n_pass++;
      n_checks++;
      if ({done, timeout, cycle_cnt} !== {1'b1, ~bh, 32'(me)})
        $display("FAIL rnd%0d_flags: got done=%b tmo=%b cyc=%0d want 1 %b %0d", r, done, timeout, cycle_cnt, ~bh, me);
      else n_pass++;
      n_checks++;
      if ({wb_cnt, trace_count, trace_overflow} !== {32'(m_wb), 4'(mq.size()), m_ovf})
        $display("FAIL rnd%0d_trace: got wb=%0d tc=%0d ovf=%b want %0d %0d %b",
                 r, wb_cnt, trace_count, trace_overflow, m_wb, mq.size(), m_ovf);
      else n_pass++;
      cr_low = 0;
      lim = (run_edges > 30) ? 30 : run_edges;
      for (int i = 1; i <= lim; i++) if (obs_cr[i] == 1'b0) cr_low++;
      n_checks++;
      if (cr_low !== me - 1) $display("FAIL rnd%0d_cpureset: got %0d low cycles want %0d", r, cr_low, me - 1);
      else n_pass++;
      for (int k = 0; k < TD && mq.size() > 0; k++) begin
        exp_e = mq.pop_front();
        n_checks++;
        if (trd_data !== exp_e) $display("FAIL rnd%0d_pop%0d: got %h want %h", r, k, trd_data, exp_e);
        else n_pass++;
        trd_en = 1'b1;
        tick();
        trd_en = 1'b0;
      end
      n_checks++;
      if (trace_empty !== 1'b1) $display("FAIL rnd%0d_drained: got empty=%b want 1", r, trace_empty);
      else n_pass++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; start = 1'b0; wb_valid = 1'b0; trd_en = 1'b0;
    pc = 32'd0; wb_addr = 5'd0; wb_data = 32'd0;
    clear_seq();
    test_reset();
    test_start_timing();
    test_mid_reset();
    test_halt();
    test_timeout();
    test_trace_filter();
    test_overflow();
    test_restart();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mips_run_ctrl.md
# mips_run_ctrl

Synthesizable run controller for the pipelined MIPS core. It replaces the hard-coded reset pulse and `#`-delay `$finish` of the fixed bench. It generates the core's reset for a programmable number of cycles, then counts cycles and retired register writes. It detects program end by PC stall or by cycle timeout, and keeps a circular trace buffer of the most recent GRF writes for the bench to drain. It sits between the top-level bench and the `mips` instance and drives the core's reset input.

## Interface
Parameters:
- `PC_W`, 32, PC width.
- `CNT_W`, 32, width of the cycle and write-back counters.
- `RESET_CYCLES`, 2, number of cycles `cpu_reset` is held after `start` (≥1).
- `MAX_CYCLES`, 1000, RUN-cycle budget before timeout (≥1).
- `HALT_REPEAT`, 4, number of consecutive equal-PC comparisons that declare a halt (≥1).
- `TRACE_DEPTH`, 8, trace buffer entries; must be a power of two, ≥2.

Ports:
- `clk` in 1: the single clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle pulse; honoured in IDLE and DONE only.
- `pc` in PC_W: core fetch PC.
- `wb_valid` in 1: core GRF write enable.
- `wb_addr` in 5: GRF write address.
- `wb_data` in 32: GRF write data.
- `cpu_reset` out 1: reset to the core.
- `running` out 1: high while in RUN.
- `done` out 1: run finished (sticky until `start` or `reset`).
- `timeout` out 1: run ended by budget, not by halt.
- `cycle_cnt` out CNT_W: RUN cycles elapsed.
- `wb_cnt` out CNT_W: counted GRF writes.
- `trd_en` in 1: pop the trace head.
- `trd_data` out 37: head entry `{wb_addr, wb_data}`, show-ahead.
- `trace_empty` out 1: trace buffer is empty.
- `trace_count` out log2(TRACE_DEPTH)+1: number of occupied entries.
- `trace_overflow` out 1: sticky; set when an entry was overwritten.

## Operation
- States: IDLE, RST, RUN, DONE. On `reset`, the block enters IDLE and sets:
  - `cpu_reset`=1;
  - `running`, `done`, `timeout`, `trace_overflow` = 0;
  - counters = 0;
  - trace empty, `trd_data`=0.
- IDLE: `cpu_reset`=1. On `start`, go to RST and clear the reset counter.
- RST: `cpu_reset`=1 for exactly RESET_CYCLES cycles, then go to RUN.
- Entering RST from any state clears `cycle_cnt`, `wb_cnt`, `done`, `timeout`, the trace buffer and `trace_overflow`.
- RUN: `cpu_reset`=0, `running`=1. Each cycle:
  - `cycle_cnt` += 1.
  - A counted write is `wb_valid && wb_addr!=0`. Each counted write does `wb_cnt` += 1 and pushes `{wb_addr,wb_data}` into the trace buffer.
  - `pc_q` <= `pc`. `same_cnt` <= (`pc_q_vld && pc==pc_q`) ? `same_cnt`+1 : 0. `pc_q_vld` is set after the first RUN cycle and cleared in RST.
- Halt: when `same_cnt` reaches HALT_REPEAT, go to DONE with `done`=1, `timeout`=0.
- Timeout: when `cycle_cnt` reaches MAX_CYCLES, go to DONE with `done`=1, `timeout`=1.
- Halt and timeout in the same cycle: halt wins (`timeout`=0).
- DONE: `cpu_reset`=1 to freeze the core; counters hold; trace remains readable. `start` restarts via RST. `start` in RST or RUN is ignored.
- Trace buffer: circular, write pointer and read pointer wrap modulo TRACE_DEPTH.
  - Push while full: overwrite the oldest entry, advance both pointers, `trace_overflow`=1; `trace_count` stays TRACE_DEPTH.
  - Push and pop in the same cycle while full: normal pop plus push; no overflow.
  - Pop while empty: ignored.
  - Push and pop while empty: the push lands and the pop is ignored.
  - Pops are allowed in every state.
- Counters saturate at all-ones and do not wrap.

## Timing
- `start` sampled at edge k: state is RST after edge k. `cpu_reset` stays high through edge k+RESET_CYCLES. First RUN cycle begins after edge k+RESET_CYCLES.
- `cycle_cnt` reads 1 after the first RUN edge.
- `done`, `timeout` and `cpu_reset` rise on the edge that takes the state to DONE. No core cycles run past that edge.
- Timeout edge is the one where `cycle_cnt` becomes MAX_CYCLES.
- Halt latency: after a PC freeze, `same_cnt` hits HALT_REPEAT on the HALT_REPEAT-th edge; DONE is entered on the next edge.
- Trace push is visible in `trd_data`/`trace_count` one edge after the write-back cycle. A pop takes effect at the edge where `trd_en` is high.
- `reset` mid-RUN: IDLE on the next edge; all outputs return to their reset values and trace contents are discarded.

## Test plan
- Reset/start, RESET_CYCLES=2: pulse `start` → `cpu_reset` is high for exactly 2 cycles after the start edge, then 0 with `running`=1; `cycle_cnt` is 1 one edge later.
- Halt, HALT_REPEAT=4: PC steps 0x3000, 0x3004, 0x3008, then holds 0x3008 → `done`=1, `timeout`=0, `cpu_reset`=1 on the 5th edge after the first repeat; `cycle_cnt` then freezes.
- Timeout, MAX_CYCLES=20, PC incrementing every cycle → `done`=`timeout`=1 with `cycle_cnt`=20. Also force halt and timeout on the same edge → `timeout`=0.
- Trace filtering, 3 writes ($0, $5=0x12, $31=0x3010) → `wb_cnt`=2. Pops return {5,0x12} then {31,0x3010}, then `trace_empty`=1.
- Overflow, TRACE_DEPTH=8, 10 writes ($1..$10) → `trace_count`=8, `trace_overflow`=1; the first pop returns $3. Push and pop together while full → no overflow change, count stays 8.
- Restart and mid-run reset: `start` in DONE clears counters, flags and trace. `reset` asserted mid-RUN → IDLE, `cpu_reset`=1, all counts 0.
